// File: rtl/rc5_pkg.sv
// Shared types for the RC5 job controller: job descriptor, opcode, error codes, FSM states.
package rc5_pkg;

  localparam int RC5_MAX_ROUNDS = 16;

  typedef enum logic {
    OP_ENC = 1'b0,
    OP_DEC = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ROUNDS  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rounds;
    logic [31:0] data;
  } job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD,
    ST_RELEASE,
    ST_ABORT
  } state_e;

endpackage

// File: rtl/rc5_job_ctrl_if.sv
// Request/response handshake bundle between a job producer and rc5_job_ctrl.
interface rc5_job_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [4:0]  req_rounds;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_op, req_rounds, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_rounds, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rc5_job_fifo.sv
// Synchronous job queue; pointers wrap naturally because FIFO_DEPTH is a power of two.
module rc5_job_fifo
  import rc5_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  job_t                        push_job,
  input  logic                        pop,
  output job_t                        head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  job_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_job;
  end

endmodule

// File: rtl/rc5_job_ctrl.sv
// Sequences queued RC5 jobs into the round core: validate, launch, wait, hold result, release.
// A hung core is recovered by a two-cycle core reset and reported as a timeout.
module rc5_job_ctrl
  import rc5_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_ROUNDS = RC5_MAX_ROUNDS,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_ready,
  rc5_job_ctrl_if.slave       bus,
  output logic                core_encrypt,
  output logic                core_decrypt,
  output logic [4:0]          core_rounds,
  output logic [31:0]         core_din,
  output logic                core_begin_validate,
  output logic                core_rst,
  input  logic                core_done,
  input  logic [31:0]         core_dout,
  output logic                busy
);
  localparam int         CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int         TW    = $clog2(TIMEOUT);
  localparam logic [5:0] MAX_R = 6'(MAX_ROUNDS);

  state_e        state, state_nx;
  job_t          job, head, push_job;
  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;
  logic          rounds_bad;
  logic          launched;
  logic          rst_hold;
  logic          abort_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   rsp_data_q;
  err_e          rsp_err_q;

  always_comb begin
    push_job        = '0;
    push_job.op     = op_e'(bus.req_op);
    push_job.rounds = bus.req_rounds;
    push_job.data   = bus.req_data;
  end

  rc5_job_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.req_valid),
    .push_job (push_job),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rounds_bad = ({1'b0, job.rounds} > MAX_R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && key_ready) begin
          pop      = 1'b1;
          state_nx = ST_CHECK;
        end
      end
      ST_CHECK:   state_nx = rounds_bad ? ST_HOLD : ST_LAUNCH;
      ST_LAUNCH:  state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_done)                        state_nx = ST_HOLD;
        else if (tmo_cnt == TW'(TIMEOUT - 1)) state_nx = ST_ABORT;
      end
      ST_HOLD: begin
        if (bus.rsp_ready) state_nx = launched ? ST_RELEASE : ST_IDLE;
      end
      ST_RELEASE: state_nx = ST_IDLE;
      ST_ABORT:   if (abort_cnt) state_nx = ST_HOLD;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Core reset stays high until the first clock edge after rst deasserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_hold <= 1'b1;
    else     rst_hold <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job        <= '0;
      launched   <= 1'b0;
      tmo_cnt    <= '0;
      abort_cnt  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      if (pop) job <= head;
      case (state)
        ST_CHECK: begin
          if (rounds_bad) begin
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_ROUNDS;
            launched   <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt  <= '0;
          launched <= 1'b1;
        end
        ST_WAIT: begin
          if (core_done) begin
            rsp_data_q <= core_dout;
            rsp_err_q  <= ERR_OK;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ABORT: begin
          abort_cnt <= !abort_cnt;
          if (abort_cnt) begin
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_TIMEOUT;
            launched   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_encrypt        = (state == ST_LAUNCH) && (job.op == OP_ENC);
  assign core_decrypt        = (state == ST_LAUNCH) && (job.op == OP_DEC);
  assign core_rounds         = job.rounds;
  assign core_din            = job.data;
  assign core_begin_validate = (state == ST_WAIT) || ((state == ST_HOLD) && launched);
  assign core_rst            = rst_hold || (state == ST_ABORT);

  assign bus.req_ready = !fifo_full;
  assign bus.rsp_valid = (state == ST_HOLD);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != ST_IDLE) || (fifo_count != '0);

endmodule
